// File: rtl/mistura_pkg.sv
// Shared types and constants for the mixing-tank sequencer: state encoding,
// concentration width/limit and counter widths.
package mistura_pkg;

    localparam int CONC_W      = 7;
    localparam int FILL_CNT_W  = 16;
    localparam int MIX_CNT_W   = 16;
    localparam int DRAIN_CNT_W = 8;
    localparam int BATCH_CNT_W = 8;

    localparam logic [CONC_W-1:0] CONC_MAX = 7'd100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_MIX,
        S_DRAIN,
        S_DONE,
        S_FAULT
    } state_t;

    // Concentrations are percentages; anything the sensor reports above 100 counts as 100.
    function automatic logic [CONC_W-1:0] sat_conc(input logic [CONC_W-1:0] v);
        return (v > CONC_MAX) ? CONC_MAX : v;
    endfunction

endpackage

// File: rtl/sequenciador_mistura_dosagem.sv
// Dosing decision for the FILL phase: picks which inlet valves to open so the
// measured concentration of liquid A moves toward the latched target.
module dosagem
    import mistura_pkg::*;
(
    input  logic [CONC_W-1:0] conc,
    input  logic [CONC_W-1:0] target,
    output logic              valve_a,
    output logic              valve_b
);

    logic [CONC_W-1:0] conc_sat;
    logic [CONC_W-1:0] target_sat;

    // On target both liquids flow, except at the extremes where adding the
    // other liquid would immediately push the mix off a 0% or 100% target.
    always_comb begin
        conc_sat   = sat_conc(conc);
        target_sat = sat_conc(target);
        valve_a    = 1'b0;
        valve_b    = 1'b0;
        if (conc_sat < target_sat) begin
            valve_a = 1'b1;
        end else if (conc_sat > target_sat) begin
            valve_b = 1'b1;
        end else if (target_sat == CONC_MAX) begin
            valve_a = 1'b1;
        end else if (target_sat == '0) begin
            valve_b = 1'b1;
        end else begin
            valve_a = 1'b1;
            valve_b = 1'b1;
        end
    end

endmodule

// File: rtl/sequenciador_mistura.sv
// Batch sequencer for a two-liquid mixing tank: fill to level, mix for a fixed
// time, drain past the minimum sensor, count completed batches.
module sequenciador_mistura
    import mistura_pkg::*;
#(
    parameter int MIX_CYCLES   = 16,
    parameter int DRAIN_TAIL   = 8,
    parameter int FILL_TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   L,
    input  logic                   M,
    input  logic [CONC_W-1:0]      C,
    input  logic [CONC_W-1:0]      D,
    output logic                   A,
    output logic                   B,
    output logic                   R,
    output logic                   E,
    output logic                   busy,
    output logic                   done,
    output logic                   fault,
    output logic [BATCH_CNT_W-1:0] batch_cnt
);

    localparam logic [FILL_CNT_W-1:0]  FILL_LAST  = FILL_CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [MIX_CNT_W-1:0]   MIX_LAST   = MIX_CNT_W'(MIX_CYCLES - 1);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_TAIL);

    state_t                   state, state_nx;
    logic [CONC_W-1:0]        dl, dl_nx;
    logic [FILL_CNT_W-1:0]    fill_cnt, fill_nx;
    logic [MIX_CNT_W-1:0]     mix_cnt, mix_nx;
    logic [DRAIN_CNT_W-1:0]   drain_cnt, drain_nx;
    logic                     tail_on, tail_nx;
    logic                     aborted, aborted_nx;
    logic [BATCH_CNT_W-1:0]   batch_nx;

    logic dose_a, dose_b;
    logic a_nx, b_nx, r_nx, e_nx, busy_nx, done_nx, fault_nx;

    // Fed with the next-cycle target so the valves are already right in the
    // first FILL cycle, when the target is being latched from D.
    dosagem u_dosagem (
        .conc    (C),
        .target  (dl_nx),
        .valve_a (dose_a),
        .valve_b (dose_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            dl        <= '0;
            fill_cnt  <= '0;
            mix_cnt   <= '0;
            drain_cnt <= '0;
            tail_on   <= 1'b0;
            aborted   <= 1'b0;
            batch_cnt <= '0;
            A         <= 1'b0;
            B         <= 1'b0;
            R         <= 1'b0;
            E         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_nx;
            dl        <= dl_nx;
            fill_cnt  <= fill_nx;
            mix_cnt   <= mix_nx;
            drain_cnt <= drain_nx;
            tail_on   <= tail_nx;
            aborted   <= aborted_nx;
            batch_cnt <= batch_nx;
            A         <= a_nx;
            B         <= b_nx;
            R         <= r_nx;
            E         <= e_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            fault     <= fault_nx;
        end
    end

    // Any batch that was aborted or faulted is marked so DONE skips the count.
    always_comb begin
        state_nx   = state;
        dl_nx      = dl;
        fill_nx    = fill_cnt;
        mix_nx     = mix_cnt;
        drain_nx   = drain_cnt;
        tail_nx    = tail_on;
        aborted_nx = aborted;
        batch_nx   = batch_cnt;

        unique case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nx   = S_FILL;
                    dl_nx      = sat_conc(D);
                    fill_nx    = '0;
                    aborted_nx = 1'b0;
                end
            end
            S_FILL: begin
                if (abort) begin
                    state_nx   = S_DRAIN;
                    aborted_nx = 1'b1;
                end else if (L) begin
                    state_nx = S_MIX;
                    mix_nx   = '0;
                end else if (fill_cnt == FILL_LAST) begin
                    state_nx   = S_FAULT;
                    aborted_nx = 1'b1;
                end else begin
                    fill_nx = fill_cnt + 1'b1;
                end
            end
            S_MIX: begin
                if (abort) begin
                    state_nx   = S_DRAIN;
                    aborted_nx = 1'b1;
                end else if (!M) begin
                    state_nx   = S_FAULT;
                    aborted_nx = 1'b1;
                end else if (mix_cnt == MIX_LAST) begin
                    state_nx = S_DRAIN;
                end else begin
                    mix_nx = mix_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                // The tail starts on the first M=0 and is not re-armed if M bounces.
                if (tail_on || !M) begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state_nx = S_DONE;
                        if (!aborted) begin
                            batch_nx = batch_cnt + 1'b1;
                        end
                    end else begin
                        drain_nx = drain_cnt + 1'b1;
                        tail_nx  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            S_FAULT: begin
                if (abort) begin
                    state_nx = S_DRAIN;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (state_nx == S_DRAIN && state != S_DRAIN) begin
            drain_nx = '0;
            tail_nx  = 1'b0;
        end
    end

    // Outputs follow the state being entered, so E is never high together
    // with an inlet valve or the mixer.
    always_comb begin
        a_nx     = 1'b0;
        b_nx     = 1'b0;
        r_nx     = 1'b0;
        e_nx     = 1'b0;
        busy_nx  = (state_nx != S_IDLE);
        done_nx  = (state_nx == S_DONE);
        fault_nx = (state_nx == S_FAULT);
        unique case (state_nx)
            S_FILL: begin
                a_nx = dose_a;
                b_nx = dose_b;
                r_nx = M;
            end
            S_MIX: begin
                r_nx = 1'b1;
            end
            S_DRAIN, S_FAULT: begin
                e_nx = 1'b1;
            end
            default: begin
                e_nx = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sequenciador_mistura.sv
// Self-checking bench for sequenciador_mistura: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a phase model.
module tb_sequenciador_mistura;

    localparam int MC = 4;
    localparam int DT = 2;
    localparam int FT = 10;

    logic       clk = 1'b0;
    logic       rst, start, abort, L, M;
    logic [6:0] C, D;
    logic       A, B, R, E, busy, done, fault;
    logic [7:0] batch_cnt;
    logic [14:0] dut_vec;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    sequenciador_mistura #(
        .MIX_CYCLES   (MC),
        .DRAIN_TAIL   (DT),
        .FILL_TIMEOUT (FT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .L         (L),
        .M         (M),
        .C         (C),
        .D         (D),
        .A         (A),
        .B         (B),
        .R         (R),
        .E         (E),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .batch_cnt (batch_cnt)
    );

    always #5 clk = ~clk;

    assign dut_vec = {A, B, R, E, busy, done, fault, batch_cnt};

    // Reference model: tracks which phase the tank is in and how long it has been there.
    typedef enum int {P_IDLE, P_FILL, P_MIX, P_DRAIN, P_DONE, P_FAULT} phase_t;
    phase_t      ph        = P_IDLE;
    int          dl        = 0;
    int          in_phase  = 0;
    int          since_low = -1;
    int          batches   = 0;
    bit          aborted   = 1'b0;
    logic [14:0] exp_vec   = '0;

    function automatic logic [1:0] dose(input int c, input int t);
        int cs;
        cs = (c > 100) ? 100 : c;
        if (cs < t)   return 2'b10;
        if (cs > t)   return 2'b01;
        if (t == 100) return 2'b10;
        if (t == 0)   return 2'b01;
        return 2'b11;
    endfunction

    function automatic logic [14:0] ov(input bit a, input bit b, input bit r, input bit e,
                                       input bit bz, input bit dn, input bit ft, input int cnt);
        return {a, b, r, e, bz, dn, ft, 8'(cnt)};
    endfunction

    task automatic model_step();
        phase_t     nx;
        logic [1:0] ab;
        nx = ph;
        if (rst) begin
            ph        = P_IDLE;
            dl        = 0;
            batches   = 0;
            aborted   = 1'b0;
            in_phase  = 0;
            since_low = -1;
        end else begin
            in_phase++;
            case (ph)
                P_IDLE: if (start && !abort) begin
                    nx      = P_FILL;
                    dl      = (int'(D) > 100) ? 100 : int'(D);
                    aborted = 1'b0;
                end
                P_FILL: begin
                    if (abort)               begin nx = P_DRAIN; aborted = 1'b1; end
                    else if (L)              nx = P_MIX;
                    else if (in_phase == FT) begin nx = P_FAULT; aborted = 1'b1; end
                end
                P_MIX: begin
                    if (abort)               begin nx = P_DRAIN; aborted = 1'b1; end
                    else if (!M)             begin nx = P_FAULT; aborted = 1'b1; end
                    else if (in_phase == MC) nx = P_DRAIN;
                end
                P_DRAIN: begin
                    if (since_low >= 0) since_low++;
                    else if (!M)        since_low = 0;
                    if (since_low == DT) begin
                        nx = P_DONE;
                        if (!aborted) batches = (batches + 1) % 256;
                    end
                end
                P_DONE:  nx = P_IDLE;
                P_FAULT: if (abort) nx = P_DRAIN;
                default: nx = P_IDLE;
            endcase
            if (nx != ph) begin
                in_phase  = 0;
                since_low = -1;
            end
            ph = nx;
        end
        ab = (ph == P_FILL) ? dose(int'(C), dl) : 2'b00;
        exp_vec = ov(ab[1], ab[0],
                     (ph == P_FILL) ? M : (ph == P_MIX),
                     (ph == P_DRAIN) || (ph == P_FAULT),
                     ph != P_IDLE, ph == P_DONE, ph == P_FAULT, batches);
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (check_en) begin
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL cycle_compare t=%0t got {A,B,R,E,busy,done,fault,cnt}=%b want %b",
                         $time, dut_vec, exp_vec);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit s, input bit a, input bit l, input bit m,
                                 input int c, input int d);
        start = s;
        abort = a;
        L     = l;
        M     = m;
        C     = 7'(c);
        D     = 7'(d);
    endtask

    task automatic checkOutput(input string name, input logic [14:0] want);
        n_checks++;
        if (dut_vec !== want) begin
            n_fail++;
            $display("[TB] FAIL %s got %b want %b", name, dut_vec, want);
        end
    endtask

    task automatic wait_done(input string name, input int bound);
        int k;
        k = 0;
        while (done !== 1'b1 && k < bound) begin
            step();
            k++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL %s got done=%b want done=1 within %0d cycles", name, done, bound);
        end
    endtask

    // Abort the running batch, empty the tank and return to IDLE.
    task automatic finish_batch(input string name);
        applyStimulus(0, 1, 0, 1, int'(C), int'(D));
        step();
        applyStimulus(0, 0, 0, 0, int'(C), int'(D));
        wait_done(name, 20);
        step();
        M = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 1, 0, 0);
        check_en = 1'b1;
        repeat (2) step();
        checkOutput("reset", ov(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        step();

        $display("[TB] nominal batch");
        applyStimulus(1, 0, 0, 1, 40, 60);
        step();
        checkOutput("nom_fill_a", ov(1, 0, 1, 0, 1, 0, 0, 0));
        applyStimulus(0, 0, 0, 1, 60, 60);
        step();
        checkOutput("nom_fill_ab", ov(1, 1, 1, 0, 1, 0, 0, 0));
        applyStimulus(0, 0, 1, 1, 60, 60);
        step();
        checkOutput("nom_mix1", ov(0, 0, 1, 0, 1, 0, 0, 0));
        repeat (3) step();
        checkOutput("nom_mix4", ov(0, 0, 1, 0, 1, 0, 0, 0));
        step();
        checkOutput("nom_drain", ov(0, 0, 0, 1, 1, 0, 0, 0));
        applyStimulus(0, 0, 1, 0, 60, 60);
        step();
        checkOutput("nom_tail1", ov(0, 0, 0, 1, 1, 0, 0, 0));
        step();
        checkOutput("nom_tail2", ov(0, 0, 0, 1, 1, 0, 0, 0));
        step();
        checkOutput("nom_done", ov(0, 0, 0, 0, 1, 1, 0, 1));
        step();
        checkOutput("nom_idle", ov(0, 0, 0, 0, 0, 0, 0, 1));

        $display("[TB] dosing boundaries");
        applyStimulus(1, 0, 0, 1, 100, 100);
        step();
        checkOutput("dose_max", ov(1, 0, 1, 0, 1, 0, 0, 1));
        finish_batch("dose_max_done");
        applyStimulus(1, 0, 0, 1, 0, 0);
        step();
        checkOutput("dose_zero", ov(0, 1, 1, 0, 1, 0, 0, 1));
        finish_batch("dose_zero_done");
        applyStimulus(1, 0, 0, 1, 100, 120);
        step();
        checkOutput("dose_d_sat", ov(1, 0, 1, 0, 1, 0, 0, 1));
        applyStimulus(0, 0, 0, 1, 127, 0);
        step();
        checkOutput("dose_c_sat", ov(1, 0, 1, 0, 1, 0, 0, 1));
        finish_batch("dose_sat_done");
        checkOutput("abort_nocount", ov(0, 0, 0, 0, 0, 0, 0, 1));

        $display("[TB] fill timeout");
        applyStimulus(1, 0, 0, 1, 50, 50);
        step();
        applyStimulus(0, 0, 0, 1, 50, 50);
        repeat (9) step();
        checkOutput("to_fill10", ov(1, 1, 1, 0, 1, 0, 0, 1));
        step();
        checkOutput("to_fault", ov(0, 0, 0, 1, 1, 0, 1, 1));
        applyStimulus(0, 1, 0, 1, 50, 50);
        step();
        checkOutput("to_drain", ov(0, 0, 0, 1, 1, 0, 0, 1));
        applyStimulus(0, 0, 0, 0, 50, 50);
        wait_done("to_done", 20);
        step();
        checkOutput("to_nocount", ov(0, 0, 0, 0, 0, 0, 0, 1));

        $display("[TB] abort during mix");
        applyStimulus(1, 0, 0, 1, 10, 50);
        step();
        applyStimulus(0, 0, 1, 1, 10, 50);
        repeat (2) step();
        applyStimulus(0, 1, 1, 1, 10, 50);
        step();
        checkOutput("abort_mix", ov(0, 0, 0, 1, 1, 0, 0, 1));
        applyStimulus(0, 0, 0, 0, 10, 50);
        wait_done("abort_mix_done", 20);
        step();
        checkOutput("abort_mix_nocount", ov(0, 0, 0, 0, 0, 0, 0, 1));

        applyStimulus(1, 1, 0, 1, 10, 50);
        step();
        checkOutput("start_abort_idle", ov(0, 0, 0, 0, 0, 0, 0, 1));

        $display("[TB] reset during fill");
        applyStimulus(1, 0, 0, 1, 20, 80);
        step();
        applyStimulus(0, 0, 0, 1, 20, 80);
        step();
        checkOutput("rst_pre", ov(1, 0, 1, 0, 1, 0, 0, 1));
        rst = 1'b1;
        step();
        checkOutput("rst_mid", ov(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        $display("[TB] randomized run");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0,
                          int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;

        $display("[TB] batch counter wrap");
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1, 0, 1, 1, 50, 50);
            step();
            applyStimulus(0, 0, 1, 1, 50, 50);
            repeat (5) step();
            applyStimulus(0, 0, 1, 0, 50, 50);
            wait_done("wrap_done", 20);
            if (i == 254) checkOutput("wrap_255", ov(0, 0, 0, 0, 1, 1, 0, 255));
            step();
        end
        checkOutput("wrap_0", ov(0, 0, 0, 0, 0, 0, 0, 0));

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sequenciador_mistura.md
SEQUENCIADOR_MISTURA -- requirements
Module: sequenciador_mistura

Interface
REQ-001 SHALL have parameter MIX_CYCLES, default 16, meaning cycles the mixer runs in MIX (1..65535).
REQ-002 SHALL have parameter DRAIN_TAIL, default 8, meaning extra drain cycles after M falls (0..255).
REQ-003 SHALL have parameter FILL_TIMEOUT, default 1000, meaning the maximum FILL cycles before FAULT (1..65535).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, which requests a batch; sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1, which forces drain from any active state.
REQ-008 SHALL have port L, input, 1, the volume-limit level sensor (1 = reached).
REQ-009 SHALL have port M, input, 1, the minimum-level sensor (1 = liquid above minimum).
REQ-010 SHALL have port C, input, 7, the current concentration of liquid A (0..100).
REQ-011 SHALL have port D, input, 7, the target concentration of liquid A (0..100).
REQ-012 SHALL have outputs A, B, R, E, each 1 bit: valve A, valve B, mixer, and drain valve (all active-high).
REQ-013 SHALL have outputs busy (1 bit), done (1-cycle pulse), fault (1 bit) and batch_cnt (8 bits).

Function
REQ-014 SHALL implement states IDLE, FILL, MIX, DRAIN, DONE and FAULT; all outputs SHALL be registered, so they change 1 cycle after the causing input or state edge.
REQ-015 IDLE: if start=1 and abort=0, latch D as Dl and go to FILL; Dl SHALL be set to 100 when D>100; clear the fill counter.
REQ-016 FILL dosing per cycle:
- C<Dl: A=1, B=0.
- C>Dl: A=0, B=1.
- C==Dl: A=1, B=1, except A-only when Dl=100 and B-only when Dl=0.
- C values above 100 SHALL be treated as 100.
REQ-017 FILL: R SHALL be 1 while M=1; E SHALL be 0.
REQ-018 FILL exits to MIX in the cycle L=1 is sampled; A and B SHALL be 0 from the next cycle.
REQ-019 FILL: if the fill counter reaches FILL_TIMEOUT with L=0, the block SHALL go to FAULT.
REQ-020 MIX: A=B=E=0 and R=1 for exactly MIX_CYCLES cycles, then go to DRAIN.
REQ-021 MIX: if M=0 is sampled, the block SHALL go to FAULT.
REQ-022 DRAIN: E=1 and A=B=R=0; once M=0, E SHALL stay 1 for DRAIN_TAIL more cycles, then go to DONE.
REQ-023 DONE: done=1 for exactly one cycle; batch_cnt SHALL increment by 1 modulo 256 (255 wraps to 0); then go to IDLE.
REQ-024 FAULT: A=B=R=0 and E=1; fault=1 until rst, or until abort=1 is sampled, which goes to DRAIN.
REQ-025 abort=1 in FILL or MIX SHALL go to DRAIN next cycle, overriding all other transitions.
REQ-026 An aborted batch SHALL still end in DONE but SHALL NOT increment batch_cnt.
REQ-027 If start=1 and abort=1 in the same IDLE cycle, abort SHALL win and the block SHALL stay in IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 A and B SHALL never be 1 while E=1, and R SHALL never be 1 while E=1.

Reset
REQ-030 rst=1 SHALL, at the next clock edge, force IDLE and set A=B=R=E=0, busy=0, done=0, fault=0, batch_cnt=0, all counters=0 and Dl=0, including mid-batch.

Structure
REQ-031 Package mistura_pkg SHALL hold the state enum, the concentration width (7), the CONC_MAX constant (100) and the counter widths.
REQ-032 The FILL dosing decision (REQ-016) SHALL be a combinational sub-module named dosagem; the FSM and counters SHALL be in sequenciador_mistura.

Verification
REQ-033 Nominal batch (MIX_CYCLES=4, DRAIN_TAIL=2): start with D=60, C=40 -> A only; set C=60 -> A=B=1; raise L -> 4 cycles with R only; drop M -> E held 2 more cycles; done pulses once; batch_cnt=1.
REQ-034 Dosing boundaries: D=100 with C=100 and L=0 -> A=1, B=0; D=0 with C=0 -> A=0, B=1; D=120 -> treated as 100.
REQ-035 Fill timeout (FILL_TIMEOUT=10): L held 0 -> FAULT after 10 FILL cycles with E=1, fault=1; then abort -> DRAIN -> DONE with batch_cnt unchanged.
REQ-036 Abort mid-MIX -> next cycle R=0, E=1; completes via DONE with no count increment; start+abort together in IDLE -> stays IDLE.
REQ-037 rst asserted mid-FILL -> all outputs 0 next cycle; 256 completed batches -> batch_cnt wraps to 0.
